decodificador_hora_12: RTL and testbench

DECODIFICADOR_HORA_12 -- requirements
Module: decodificador_hora_12

---
 rtl/decodificador_hora_12.sv | 122 ++++++++++++
 tb/tb_decodificador_hora_12.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/decodificador_hora_12.sv
//------------------------------------------------------------------------------
// decodificador_hora_12 : 12-hour BCD hour byte to 24-hour binary decoder (FSM).
// Optional 24-hour BCD output enabled by macro HORA_BCD24_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decodificador_hora_12 (
    input  logic       clk,
    input  logic       rst,
    input  logic       EN,
    input  logic [7:0] h_in,
    input  logic       valid,
    output logic       ready,
    output logic [4:0] hora24,
    output logic [7:0] hora24_bcd,
    output logic       done,
    output logic       err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_CONV  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0] state;
    logic [7:0] h_cap;
    logic       bad;

    logic       tens;
    logic [3:0] units;
    logic       pm;
    logic       bad_next;
    logic [4:0] value12;
    logic [4:0] hora_next;

    assign tens  = h_cap[4];
    assign units = h_cap[3:0];
    assign pm    = h_cap[7];

    assign bad_next = (h_cap[6:5] != 2'b00)
                    | (units > 4'd9)
                    | (tens & (units > 4'd2))
                    | (~tens & (units == 4'd0));

    assign value12 = tens ? (5'd10 + {1'b0, units}) : {1'b0, units};

    // 12 AM is midnight (0), 12 PM is noon (12); other PM hours shift by 12.
    always_comb begin
        hora_next = value12;
        if (value12 == 5'd12)
            hora_next = pm ? 5'd12 : 5'd0;
        else if (pm)
            hora_next = value12 + 5'd12;
    end

    assign ready = (state == S_IDLE) & EN & ~rst;
    assign done  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            h_cap  <= 8'h00;
            bad    <= 1'b0;
            hora24 <= 5'd0;
            err    <= 1'b0;
        end else if (EN) begin
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        h_cap <= h_in;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    bad   <= bad_next;
                    state <= S_CONV;
                end
                S_CONV: begin
                    if (bad) begin
                        err <= 1'b1;
                    end else begin
                        err    <= 1'b0;
                        hora24 <= hora_next;
                    end
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef HORA_BCD24_EN
    logic [3:0] bcd_tens;
    logic [4:0] bcd_units;

    always_comb begin
        if (hora_next >= 5'd20) begin
            bcd_tens  = 4'd2;
            bcd_units = hora_next - 5'd20;
        end else if (hora_next >= 5'd10) begin
            bcd_tens  = 4'd1;
            bcd_units = hora_next - 5'd10;
        end else begin
            bcd_tens  = 4'd0;
            bcd_units = hora_next;
        end
    end

    // Loaded on the same edge and under the same condition as hora24.
    always_ff @(posedge clk) begin
        if (rst)
            hora24_bcd <= 8'h00;
        else if (EN && state == S_CONV && !bad)
            hora24_bcd <= {bcd_tens, bcd_units[3:0]};
    end
`else
    assign hora24_bcd = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_decodificador_hora_12.sv
// Directed self-checking bench for decodificador_hora_12.
`default_nettype none

module tb_decodificador_hora_12;

    logic       clk = 1'b0;
    logic       rst;
    logic       EN;
    logic [7:0] h_in;
    logic       valid;
    logic       ready;
    logic [4:0] hora24;
    logic [7:0] hora24_bcd;
    logic       done;
    logic       err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    decodificador_hora_12 dut (
        .clk        (clk),
        .rst        (rst),
        .EN         (EN),
        .h_in       (h_in),
        .valid      (valid),
        .ready      (ready),
        .hora24     (hora24),
        .hora24_bcd (hora24_bcd),
        .done       (done),
        .err        (err)
    );

    function automatic logic [7:0] exp_bcd(input int v);
        logic [7:0] r;
        r = {4'(v / 10), 4'(v % 10)};
`ifndef HORA_BCD24_EN
        r = 8'h00;
`endif
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one byte, waits (bounded) for done, returns what was observed.
    task automatic run_decode(input logic [7:0] b, input logic noise,
                              output int lat, output logic rdy_acc, output logic busy_rdy,
                              output logic [4:0] h, output logic [7:0] bcd,
                              output logic e, output logic done_after);
        h_in     = b;
        valid    = 1'b1;
        rdy_acc  = ready;
        busy_rdy = 1'b0;
        step();
        lat = 1;
        if (noise) h_in = 8'h13;
        else       valid = 1'b0;
        while (!done && lat < 20) begin
            if (ready) busy_rdy = 1'b1;
            step();
            lat++;
        end
        if (ready) busy_rdy = 1'b1;
        h     = hora24;
        bcd   = hora24_bcd;
        e     = err;
        valid = 1'b0;
        step();
        done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; EN = 1'b1; valid = 1'b0; h_in = 8'h00;
        step(); step();
        total++; if (ready !== 1'b0) $display("FAIL reset_ready_during_rst: got %b expected 0", ready); else passed++;
        rst = 1'b0;
        #1;
        total++; if (ready !== 1'b1) $display("FAIL reset_ready_after: got %b expected 1", ready); else passed++;
        total++; if (hora24 !== 5'd0) $display("FAIL reset_hora24: got %0d expected 0", hora24); else passed++;
        total++; if (hora24_bcd !== 8'h00) $display("FAIL reset_bcd: got %h expected 00", hora24_bcd); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else passed++;
    endtask

    task automatic test_midnight();
        int lat; logic ra, br, e, da; logic [4:0] h; logic [7:0] bcd;
        run_decode(8'h12, 1'b0, lat, ra, br, h, bcd, e, da);
        total++; if (ra !== 1'b1) $display("FAIL mid_ready_accept: got %b expected 1", ra); else passed++;
        total++; if (lat != 3) $display("FAIL mid_latency: got %0d expected 3", lat); else passed++;
        total++; if (br !== 1'b0) $display("FAIL mid_ready_busy: got %b expected 0", br); else passed++;
        total++; if (h !== 5'd0) $display("FAIL mid_hora24: got %0d expected 0", h); else passed++;
        total++; if (e !== 1'b0) $display("FAIL mid_err: got %b expected 0", e); else passed++;
        total++; if (bcd !== 8'h00) $display("FAIL mid_bcd: got %h expected 00", bcd); else passed++;
        total++; if (da !== 1'b0) $display("FAIL mid_done_one_cycle: got %b expected 0", da); else passed++;
    endtask

    task automatic test_pm();
        int lat; logic ra, br, e, da; logic [4:0] h; logic [7:0] bcd;
        run_decode(8'h92, 1'b0, lat, ra, br, h, bcd, e, da);
        total++; if (h !== 5'd12) $display("FAIL pm_noon_hora24: got %0d expected 12", h); else passed++;
        total++; if (bcd !== exp_bcd(12)) $display("FAIL pm_noon_bcd: got %h expected %h", bcd, exp_bcd(12)); else passed++;
        run_decode(8'h81, 1'b0, lat, ra, br, h, bcd, e, da);
        total++; if (h !== 5'd13) $display("FAIL pm_1_hora24: got %0d expected 13", h); else passed++;
        total++; if (bcd !== exp_bcd(13)) $display("FAIL pm_1_bcd: got %h expected %h", bcd, exp_bcd(13)); else passed++;
        total++; if (e !== 1'b0) $display("FAIL pm_1_err: got %b expected 0", e); else passed++;
    endtask

    task automatic test_sweep();
        logic [7:0] bytes [24] = '{8'h12, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                   8'h08, 8'h09, 8'h10, 8'h11, 8'h92, 8'h81, 8'h82, 8'h83,
                                   8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89, 8'h90, 8'h91};
        int lat; logic ra, br, e, da; logic [4:0] h; logic [7:0] bcd;
        for (int i = 0; i < 24; i++) begin
            run_decode(bytes[i], 1'b0, lat, ra, br, h, bcd, e, da);
            total++; if (h !== 5'(i)) $display("FAIL sweep_hora24 byte=%h: got %0d expected %0d", bytes[i], h, i); else passed++;
            total++; if (e !== 1'b0) $display("FAIL sweep_err byte=%h: got %b expected 0", bytes[i], e); else passed++;
            total++; if (bcd !== exp_bcd(i)) $display("FAIL sweep_bcd byte=%h: got %h expected %h", bytes[i], bcd, exp_bcd(i)); else passed++;
        end
    endtask

    task automatic test_errors();
        logic [7:0] bad_bytes [4] = '{8'h13, 8'h00, 8'h0A, 8'h21};
        int lat; logic ra, br, e, da; logic [4:0] h; logic [7:0] bcd;
        for (int i = 0; i < 4; i++) begin
            // valid held high during the busy cycles must be ignored
            run_decode(8'h05, 1'b1, lat, ra, br, h, bcd, e, da);
            total++; if (h !== 5'd5) $display("FAIL err_pre_hora24: got %0d expected 5", h); else passed++;
            total++; if (e !== 1'b0) $display("FAIL err_pre_err: got %b expected 0", e); else passed++;
            run_decode(bad_bytes[i], 1'b0, lat, ra, br, h, bcd, e, da);
            total++; if (e !== 1'b1) $display("FAIL err_flag byte=%h: got %b expected 1", bad_bytes[i], e); else passed++;
            total++; if (h !== 5'd5) $display("FAIL err_hold_hora24 byte=%h: got %0d expected 5", bad_bytes[i], h); else passed++;
            total++; if (bcd !== exp_bcd(5)) $display("FAIL err_hold_bcd byte=%h: got %h expected %h", bad_bytes[i], bcd, exp_bcd(5)); else passed++;
            total++; if (lat != 3) $display("FAIL err_latency byte=%h: got %0d expected 3", bad_bytes[i], lat); else passed++;
            total++; if (br !== 1'b0) $display("FAIL err_ready_busy byte=%h: got %b expected 0", bad_bytes[i], br); else passed++;
            step(); step();
            total++; if (err !== 1'b1) $display("FAIL err_sticky byte=%h: got %b expected 1", bad_bytes[i], err); else passed++;
        end
    endtask

    task automatic test_enable_freeze();
        int lat;
        h_in = 8'h91; valid = 1'b1;
        step();
        valid = 1'b0; lat = 1;
        step(); lat++;
        EN = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(); lat++;
            total++; if (done !== 1'b0) $display("FAIL en_frozen_done cycle=%0d: got %b expected 0", k, done); else passed++;
        end
        EN = 1'b1;
        while (!done && lat < 30) begin
            step(); lat++;
        end
        total++; if (lat != 7) $display("FAIL en_latency: got %0d expected 7", lat); else passed++;
        total++; if (hora24 !== 5'd23) $display("FAIL en_hora24: got %0d expected 23", hora24); else passed++;
        EN = 1'b0;
        step(); step();
        total++; if (done !== 1'b1) $display("FAIL en_done_held: got %b expected 1", done); else passed++;
        total++; if (ready !== 1'b0) $display("FAIL en_ready_disabled: got %b expected 0", ready); else passed++;
        EN = 1'b1;
        step();
        total++; if (done !== 1'b0) $display("FAIL en_done_release: got %b expected 0", done); else passed++;
        total++; if (ready !== 1'b1) $display("FAIL en_ready_idle: got %b expected 1", ready); else passed++;
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        h_in = 8'h91; valid = 1'b1;
        step();
        valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        total++; if (ready !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", ready); else passed++;
        total++; if (hora24 !== 5'd0) $display("FAIL rstmid_hora24: got %0d expected 0", hora24); else passed++;
        total++; if (hora24_bcd !== 8'h00) $display("FAIL rstmid_bcd: got %h expected 00", hora24_bcd); else passed++;
        saw_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (done) saw_done = 1'b1;
            step();
        end
        total++; if (saw_done !== 1'b0) $display("FAIL rstmid_no_done: got %b expected 0", saw_done); else passed++;
    endtask

    initial begin
        rst = 1'b1; EN = 1'b1; valid = 1'b0; h_in = 8'h00;
        test_reset();
        test_midnight();
        test_pm();
        test_sweep();
        test_errors();
        test_enable_freeze();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
